// File: rtl/led_jellyant.sv
// LED tile: free-running counter mapped to one of four 8-LED patterns.
// The counter is exported on data; bidirectional pins are parked as inputs.
module led_jellyant #(
    parameter int WIDTH = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [7:0]       ui_in,
    input  logic [7:0]       uio_in,
    output logic [7:0]       uo_out,
    output logic [7:0]       uio_out,
    output logic [7:0]       uio_oe,
    output logic [WIDTH-1:0] data
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [3:0]       bounce_i;
    logic [2:0]       bounce_p;
    logic [7:0]       pat;

    // Count only while the tile is selected and hold (ui_in[7]) is low.
    always_comb begin
        count_d = count_q;
        if (ena && !ui_in[7]) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Bounce folds 0..15 into 0..7..0; for i>=8, 15-i equals ~i[2:0].
    always_comb begin
        bounce_i = count_q[WIDTH-1 -: 4];
        bounce_p = bounce_i[3] ? ~bounce_i[2:0] : bounce_i[2:0];
        pat      = '0;
        case (ui_in[1:0])
            2'b00:   pat = count_q[WIDTH-1 -: 8];
            2'b01:   pat = 8'b1 << count_q[WIDTH-1 -: 3];
            2'b10:   pat = 8'b1 << bounce_p;
            default: pat = {8{count_q[WIDTH-1]}};
        endcase
    end

    assign uo_out  = pat ^ {8{ui_in[2]}};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;
    assign data    = count_q;

    logic unused_ok;
    assign unused_ok = &{1'b0, uio_in, ui_in[6:3]};

endmodule

// File: tb/tb_led_jellyant.sv
// Directed bench for led_jellyant: full-width instance for count/hold/reset,
// a 10-bit instance for pattern taps and wrap-around at reachable counts.
module tb_led_jellyant;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic [7:0]  ui_in;
    logic [7:0]  uo_out;
    logic [7:0]  uio_out;
    logic [7:0]  uio_oe;
    logic [25:0] data;

    logic        rst_n_s;
    logic [7:0]  ui_in_s;
    logic [7:0]  uo_out_s;
    logic [7:0]  uio_out_s;
    logic [7:0]  uio_oe_s;
    logic [9:0]  data_s;

    int total = 0;
    int bad   = 0;

    logic [25:0] exp_q[$];
    logic [9:0]  exp_s_q[$];
    logic [25:0] m_cnt;
    logic [9:0]  m_s;

    led_jellyant #(.WIDTH(26)) u_dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(8'h00),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe), .data(data)
    );

    led_jellyant #(.WIDTH(10)) u_small (
        .clk(clk), .rst_n(rst_n_s), .ena(1'b1), .ui_in(ui_in_s), .uio_in(8'hA5),
        .uo_out(uo_out_s), .uio_out(uio_out_s), .uio_oe(uio_oe_s), .data(data_s)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Independent pattern model for the 10-bit instance.
    function automatic logic [7:0] model_pat(input logic [9:0] c, input logic [7:0] ui);
        int i;
        int p;
        logic [7:0] r;
        i = int'(c) / 64;
        p = (i < 8) ? i : 15 - i;
        case (ui[1:0])
            2'd0:    r = c[9:2];
            2'd1:    r = 8'(1 << (int'(c) / 128));
            2'd2:    r = 8'(1 << p);
            default: r = (c >= 10'd512) ? 8'hFF : 8'h00;
        endcase
        return ui[2] ? ~r : r;
    endfunction

    // driver: push expected counter, clock once, pop and compare
    task automatic step(input string tag);
        logic [25:0] e;
        e = (ena && !ui_in[7]) ? m_cnt + 26'd1 : m_cnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        m_cnt = exp_q.pop_front();
        check(tag, 32'(data), 32'(m_cnt));
    endtask

    task automatic step_s(input string tag);
        logic [9:0] e;
        e = ui_in_s[7] ? m_s : m_s + 10'd1;
        exp_s_q.push_back(e);
        @(posedge clk);
        #1;
        m_s = exp_s_q.pop_front();
        check(tag, 32'(data_s), 32'(m_s));
    endtask

    task automatic run_s(input int n);
        for (int k = 0; k < n; k++) step_s("small_data");
    endtask

    initial begin
        rst_n   = 1'b0;
        ena     = 1'b1;
        ui_in   = 8'h00;
        rst_n_s = 1'b0;
        ui_in_s = 8'h00;
        m_cnt   = '0;
        m_s     = '0;

        // Reset held for 10 cycles
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
        end
        check("rst_data", 32'(data), 32'd0);
        check("rst_uo", 32'(uo_out), 32'h00);
        check("uio_out", 32'(uio_out), 32'h00);
        check("uio_oe", 32'(uio_oe), 32'h00);
        check("small_rst", 32'(data_s), 32'd0);

        // Count 1000 edges
        rst_n = 1'b1;
        for (int k = 0; k < 1000; k++) step("count");
        check("count_1000", 32'(data), 32'd1000);
        check("count_uo", 32'(uo_out), 32'h00);

        // Hold, then ena=0
        ui_in = 8'h80;
        for (int k = 0; k < 20; k++) step("hold");
        check("hold_frozen", 32'(data), 32'd1000);
        ui_in = 8'h00;
        step("hold_release");
        check("hold_next", 32'(data), 32'd1001);
        ena = 1'b0;
        for (int k = 0; k < 20; k++) step("ena_off");
        check("ena_frozen", 32'(data), 32'd1001);
        ena = 1'b1;
        step("ena_release");
        check("ena_next", 32'(data), 32'd1002);

        // Modes at small count, combinational response
        ui_in = 8'h00; #1 check("mode_00", 32'(uo_out), 32'h00);
        ui_in = 8'h01; #1 check("mode_01", 32'(uo_out), 32'h01);
        ui_in = 8'h02; #1 check("mode_02", 32'(uo_out), 32'h01);
        ui_in = 8'h03; #1 check("mode_03", 32'(uo_out), 32'h00);
        ui_in = 8'h07; #1 check("mode_07", 32'(uo_out), 32'hFF);
        ui_in = 8'h04; #1 check("mode_04", 32'(uo_out), 32'hFF);
        ui_in = 8'h78; #1 check("ignored_bits", 32'(uo_out), 32'h00);
        step("ignored_count");
        ui_in = 8'h00;

        // Async reset mid-run at data=123
        rst_n = 1'b0;
        #1 check("async_rst0", 32'(data), 32'd0);
        rst_n = 1'b1;
        m_cnt = '0;
        for (int k = 0; k < 123; k++) step("to_123");
        check("at_123", 32'(data), 32'd123);
        #2 rst_n = 1'b0;
        #1 check("async_rst_mid", 32'(data), 32'd0);
        check("async_rst_uo", 32'(uo_out), 32'h00);
        #1 rst_n = 1'b1;
        m_cnt = '0;
        step("resume_1");
        check("resume_1_abs", 32'(data), 32'd1);
        step("resume_2");
        step("resume_3");
        check("resume_3_abs", 32'(data), 32'd3);

        // Pattern taps and wrap on the 10-bit instance
        rst_n_s = 1'b1;
        run_s(4);
        ui_in_s = 8'h00; #1 check("s_mode00", 32'(uo_out_s), 32'h01);
        run_s(124);
        ui_in_s = 8'h01; #1 check("s_mode01", 32'(uo_out_s), 32'h02);
        run_s(384);
        ui_in_s = 8'h03; #1 check("s_mode11", 32'(uo_out_s), 32'hFF);
        run_s(64);
        ui_in_s = 8'h02; #1 check("s_mode10", 32'(uo_out_s), 32'h40);
        ui_in_s = 8'h06; #1 check("s_mode10_inv", 32'(uo_out_s), 32'hBF);
        run_s(447);
        check("s_pre_wrap", 32'(data_s), 32'h3FF);
        step_s("s_wrap");
        check("s_wrap_zero", 32'(data_s), 32'd0);
        check("s_uio", 32'({uio_out_s, uio_oe_s}), 32'h0);

        // Random controls against the pattern model
        for (int k = 0; k < 60; k++) begin
            ui_in_s = 8'($urandom_range(0, 255));
            #1 check("s_rand_pat", 32'(uo_out_s), 32'(model_pat(m_s, ui_in_s)));
            run_s($urandom_range(1, 40));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
